// File: rtl/tight_acc_mm_ctrl.sv
// Controller for a tightly coupled DIM x DIM matrix-multiply accelerator: operand fill, MULT sequencing, result read-back.
// Optional build macro TACC_MM_CTRL_STRICT_EN rejects out-of-order commands with an all-ones response.
module tight_acc_mm_ctrl #(
    parameter int DIM    = 10,
    parameter int DATA_W = 64,
    parameter int AW     = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_val,
    output logic              busy,
    input  logic [5:0]        cmd_opcode,
    input  logic [DATA_W-1:0] cmd_config_data,
    output logic              resp_val,
    input  logic              resp_rdy,
    output logic [DATA_W-1:0] resp_data,
    output logic              buf_wr_en,
    output logic              buf_wr_sel,
    output logic [AW-1:0]     buf_wr_addr,
    output logic [DATA_W-1:0] buf_wr_data,
    output logic [AW-1:0]     mac_a_addr,
    output logic [AW-1:0]     mac_b_addr,
    output logic              mac_en,
    output logic              mac_clr,
    output logic              res_wr_en,
    output logic [AW-1:0]     res_wr_addr,
    output logic [AW-1:0]     res_rd_addr,
    input  logic [DATA_W-1:0] res_rd_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_RD, S_RD_WAIT, S_MULT, S_DRAIN, S_RESP
    } state_t;

    localparam logic [5:0]        OP_INIT   = 6'd10;
    localparam logic [5:0]        OP_FILLA  = 6'd11;
    localparam logic [5:0]        OP_FILLB  = 6'd12;
    localparam logic [5:0]        OP_READ   = 6'd13;
    localparam logic [5:0]        OP_MULT   = 6'd25;
    localparam logic [AW-1:0]     DIM_A     = AW'(DIM);
    localparam logic [AW-1:0]     LAST_IDX  = AW'(DIM - 1);
    localparam logic [AW-1:0]     LAST_ADDR = AW'(DIM * DIM - 1);
    localparam logic [DATA_W-1:0] DONE_RESP = DATA_W'(DIM * DIM);

    state_t              state_q;
    logic [AW-1:0]       a_ptr_q, b_ptr_q, rd_ptr_q;
    logic [AW-1:0]       i_q, j_q, k_q;
    logic [AW-1:0]       i_d, j_d, k_d;
    logic                drain_cnt_q;
    logic                wr_p1_q;
    logic [AW-1:0]       wr_addr_p1_q;
    logic [DATA_W-1:0]   resp_data_q;
    logic                buf_wr_en_q, buf_wr_sel_q;
    logic [AW-1:0]       buf_wr_addr_q;
    logic [DATA_W-1:0]   buf_wr_data_q;
    logic [AW-1:0]       mac_a_addr_q, mac_b_addr_q;
    logic                mac_en_q, mac_clr_q;
    logic                res_wr_en_q;
    logic [AW-1:0]       res_wr_addr_q, res_rd_addr_q;
    logic                last_k, last_j, last_i;
    logic                cmd_err;
`ifdef TACC_MM_CTRL_STRICT_EN
    logic                res_valid_q, a_full_q, b_full_q;
`endif

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + AW'(1);
    endfunction

    assign last_k = (k_q == LAST_IDX);
    assign last_j = (j_q == LAST_IDX);
    assign last_i = (i_q == LAST_IDX);

    // Loop nest i, j, k with k innermost; wraps to 0,0,0 after the final beat.
    always_comb begin
        i_d = i_q;
        j_d = j_q;
        k_d = k_q + AW'(1);
        if (last_k) begin
            k_d = '0;
            j_d = j_q + AW'(1);
            if (last_j) begin
                j_d = '0;
                i_d = last_i ? '0 : i_q + AW'(1);
            end
        end
    end

    always_comb begin
        cmd_err = 1'b0;
`ifdef TACC_MM_CTRL_STRICT_EN
        case (cmd_opcode)
            OP_READ:  cmd_err = !res_valid_q;
            OP_FILLA: cmd_err = a_full_q;
            OP_FILLB: cmd_err = b_full_q;
            OP_MULT:  cmd_err = !(a_full_q && b_full_q);
            default:  cmd_err = 1'b0;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            a_ptr_q       <= '0;
            b_ptr_q       <= '0;
            rd_ptr_q      <= '0;
            i_q           <= '0;
            j_q           <= '0;
            k_q           <= '0;
            drain_cnt_q   <= 1'b0;
            wr_p1_q       <= 1'b0;
            wr_addr_p1_q  <= '0;
            resp_data_q   <= '0;
            buf_wr_en_q   <= 1'b0;
            buf_wr_sel_q  <= 1'b0;
            buf_wr_addr_q <= '0;
            buf_wr_data_q <= '0;
            mac_a_addr_q  <= '0;
            mac_b_addr_q  <= '0;
            mac_en_q      <= 1'b0;
            mac_clr_q     <= 1'b0;
            res_wr_en_q   <= 1'b0;
            res_wr_addr_q <= '0;
            res_rd_addr_q <= '0;
`ifdef TACC_MM_CTRL_STRICT_EN
            res_valid_q   <= 1'b0;
            a_full_q      <= 1'b0;
            b_full_q      <= 1'b0;
`endif
        end else begin
            buf_wr_en_q   <= 1'b0;
            mac_en_q      <= 1'b0;
            mac_clr_q     <= 1'b0;
            wr_p1_q       <= 1'b0;
            // Result write trails the k=DIM-1 beat by two cycles (buffer read + accumulate).
            res_wr_en_q   <= wr_p1_q;
            res_wr_addr_q <= wr_addr_p1_q;
            case (state_q)
                S_IDLE: begin
                    if (cmd_val) begin
                        if (cmd_err) begin
                            resp_data_q <= '1;
                            state_q     <= S_RESP;
                        end else begin
                            case (cmd_opcode)
                                OP_INIT: begin
                                    a_ptr_q     <= '0;
                                    b_ptr_q     <= '0;
                                    rd_ptr_q    <= '0;
`ifdef TACC_MM_CTRL_STRICT_EN
                                    res_valid_q <= 1'b0;
                                    a_full_q    <= 1'b0;
                                    b_full_q    <= 1'b0;
`endif
                                    resp_data_q <= '0;
                                    state_q     <= S_RESP;
                                end
                                OP_FILLA, OP_FILLB: begin
                                    buf_wr_en_q   <= 1'b1;
                                    buf_wr_data_q <= cmd_config_data;
                                    if (cmd_opcode == OP_FILLB) begin
                                        buf_wr_sel_q  <= 1'b1;
                                        buf_wr_addr_q <= b_ptr_q;
                                        b_ptr_q       <= bump(b_ptr_q);
`ifdef TACC_MM_CTRL_STRICT_EN
                                        b_full_q      <= b_full_q || (b_ptr_q == LAST_ADDR);
`endif
                                    end else begin
                                        buf_wr_sel_q  <= 1'b0;
                                        buf_wr_addr_q <= a_ptr_q;
                                        a_ptr_q       <= bump(a_ptr_q);
`ifdef TACC_MM_CTRL_STRICT_EN
                                        a_full_q      <= a_full_q || (a_ptr_q == LAST_ADDR);
`endif
                                    end
                                    state_q <= S_FILL;
                                end
                                OP_READ: begin
                                    res_rd_addr_q <= rd_ptr_q;
                                    state_q       <= S_RD;
                                end
                                OP_MULT: begin
                                    i_q          <= '0;
                                    j_q          <= '0;
                                    k_q          <= '0;
                                    mac_a_addr_q <= '0;
                                    mac_b_addr_q <= '0;
                                    state_q      <= S_MULT;
                                end
                                default: begin
                                    resp_data_q <= '0;
                                    state_q     <= S_RESP;
                                end
                            endcase
                        end
                    end
                end
                S_FILL: begin
                    resp_data_q <= DATA_W'(buf_wr_addr_q);
                    state_q     <= S_RESP;
                end
                S_RD: state_q <= S_RD_WAIT;
                S_RD_WAIT: begin
                    resp_data_q <= res_rd_data;
                    rd_ptr_q    <= bump(rd_ptr_q);
                    state_q     <= S_RESP;
                end
                S_MULT: begin
                    mac_en_q     <= 1'b1;
                    mac_clr_q    <= (k_q == '0);
                    wr_p1_q      <= last_k;
                    wr_addr_p1_q <= i_q * DIM_A + j_q;
                    i_q          <= i_d;
                    j_q          <= j_d;
                    k_q          <= k_d;
                    mac_a_addr_q <= i_d * DIM_A + k_d;
                    mac_b_addr_q <= k_d * DIM_A + j_d;
                    if (last_i && last_j && last_k) begin
                        drain_cnt_q <= 1'b0;
                        state_q     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_q) begin
`ifdef TACC_MM_CTRL_STRICT_EN
                        res_valid_q <= 1'b1;
`endif
                        resp_data_q <= DONE_RESP;
                        state_q     <= S_RESP;
                    end else begin
                        drain_cnt_q <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_rdy) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign resp_val    = (state_q == S_RESP);
    assign resp_data   = resp_data_q;
    assign buf_wr_en   = buf_wr_en_q;
    assign buf_wr_sel  = buf_wr_sel_q;
    assign buf_wr_addr = buf_wr_addr_q;
    assign buf_wr_data = buf_wr_data_q;
    assign mac_a_addr  = mac_a_addr_q;
    assign mac_b_addr  = mac_b_addr_q;
    assign mac_en      = mac_en_q;
    assign mac_clr     = mac_clr_q;
    assign res_wr_en   = res_wr_en_q;
    assign res_wr_addr = res_wr_addr_q;
    assign res_rd_addr = res_rd_addr_q;

endmodule

// File: tb/tb_tight_acc_mm_ctrl.sv
// Directed bench for tight_acc_mm_ctrl with behavioural operand/result buffers and MAC around the controller.
`timescale 1ns/1ps
module tb_tight_acc_mm_ctrl;

    localparam int DIM    = 10;
    localparam int DATA_W = 64;
    localparam int AW     = 7;
    localparam int N      = DIM * DIM;
    localparam logic [5:0] OP_INIT  = 6'd10;
    localparam logic [5:0] OP_FILLA = 6'd11;
    localparam logic [5:0] OP_FILLB = 6'd12;
    localparam logic [5:0] OP_READ  = 6'd13;
    localparam logic [5:0] OP_MULT  = 6'd25;
    localparam logic [DATA_W-1:0] ONES = '1;
`ifdef TACC_MM_CTRL_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cmd_val;
    logic              busy;
    logic [5:0]        cmd_opcode;
    logic [DATA_W-1:0] cmd_config_data;
    logic              resp_val;
    logic              resp_rdy;
    logic [DATA_W-1:0] resp_data;
    logic              buf_wr_en;
    logic              buf_wr_sel;
    logic [AW-1:0]     buf_wr_addr;
    logic [DATA_W-1:0] buf_wr_data;
    logic [AW-1:0]     mac_a_addr;
    logic [AW-1:0]     mac_b_addr;
    logic              mac_en;
    logic              mac_clr;
    logic              res_wr_en;
    logic [AW-1:0]     res_wr_addr;
    logic [AW-1:0]     res_rd_addr;
    logic [DATA_W-1:0] res_rd_data;

    always #5 clk = ~clk;

    tight_acc_mm_ctrl #(.DIM(DIM), .DATA_W(DATA_W), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_val(cmd_val), .busy(busy), .cmd_opcode(cmd_opcode), .cmd_config_data(cmd_config_data),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data),
        .buf_wr_en(buf_wr_en), .buf_wr_sel(buf_wr_sel), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .mac_a_addr(mac_a_addr), .mac_b_addr(mac_b_addr), .mac_en(mac_en), .mac_clr(mac_clr),
        .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr),
        .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data)
    );

    // Environment: operand buffers, MAC accumulator and result buffer, all 1-cycle read latency.
    logic [DATA_W-1:0] a_mem [0:(1<<AW)-1];
    logic [DATA_W-1:0] b_mem [0:(1<<AW)-1];
    logic [DATA_W-1:0] r_mem [0:(1<<AW)-1];
    logic [DATA_W-1:0] a_rd, b_rd, acc;

    always @(posedge clk) begin
        if (buf_wr_en) begin
            if (buf_wr_sel) b_mem[buf_wr_addr] <= buf_wr_data;
            else            a_mem[buf_wr_addr] <= buf_wr_data;
        end
        a_rd <= a_mem[mac_a_addr];
        b_rd <= b_mem[mac_b_addr];
        if (mac_en) acc <= (mac_clr ? '0 : acc) + a_rd * b_rd;
        if (res_wr_en) r_mem[res_wr_addr] <= acc;
        res_rd_data <= r_mem[res_rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic              sel;
        logic [AW-1:0]     addr;
        logic [DATA_W-1:0] data;
    } bev_t;
    typedef struct packed {
        logic [31:0]   t;
        logic [AW-1:0] addr;
    } rev_t;

    bev_t buf_ev[$];
    rev_t res_ev[$];
    logic [DATA_W-1:0] exp_q[$];

    always @(negedge clk) begin
        if (buf_wr_en) buf_ev.push_back('{buf_wr_sel, buf_wr_addr, buf_wr_data});
        if (res_wr_en) res_ev.push_back('{32'(cyc), res_wr_addr});
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic any_out();
        return |{busy, resp_val, resp_data, buf_wr_en, buf_wr_sel, buf_wr_addr, buf_wr_data,
                 mac_a_addr, mac_b_addr, mac_en, mac_clr, res_wr_en, res_wr_addr, res_rd_addr};
    endfunction

    // Called on a falling edge with the controller idle; returns on a falling edge with it idle again.
    task automatic run_cmd(input string tag, input logic [5:0] op, input logic [DATA_W-1:0] d,
                           input logic [DATA_W-1:0] exp, input int budget,
                           output int t_issue, output int t_resp);
        int waited;
        logic [DATA_W-1:0] want;
        exp_q.push_back(exp);
        cmd_val = 1'b1;
        cmd_opcode = op;
        cmd_config_data = d;
        @(negedge clk);
        cmd_val = 1'b0;
        t_issue = cyc;
        waited = 0;
        while (!resp_val && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        t_resp = cyc;
        want = exp_q.pop_front();
        check({tag, "_resp_seen"}, 64'(resp_val), 64'd1);
        check(tag, resp_data, want);
        $display("txn %s op=%0d data=%0h resp=%0h want=%0h", tag, op, d, resp_data, want);
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, tr, hits;
        logic [DATA_W-1:0] held;
        bev_t be;
        rev_t re;
        rst_n = 1'b0;
        cmd_val = 1'b0;
        cmd_opcode = '0;
        cmd_config_data = '0;
        resp_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", 64'(any_out()), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_not_busy", 64'(busy), 64'd0);

        // INIT with the response stalled; a competing FILLA must not be accepted.
        exp_q.push_back('0);
        cmd_val = 1'b1;
        cmd_opcode = OP_INIT;
        resp_rdy = 1'b0;
        @(negedge clk);
        cmd_opcode = OP_FILLA;
        cmd_config_data = 64'hDEAD;
        held = exp_q.pop_front();
        for (int c = 0; c < 5; c++) begin
            check("init_stall_val", 64'(resp_val), 64'd1);
            check("init_stall_data", resp_data, held);
            check("init_stall_busy", 64'(busy), 64'd1);
            @(negedge clk);
        end
        cmd_val = 1'b0;
        resp_rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        $display("txn init_stall resp=%0h", held);
        check("init_stall_no_write", 64'(buf_ev.size()), 64'd0);

        for (int n = 0; n < N; n++) begin
            run_cmd("filla", OP_FILLA, 64'(n), 64'(n), 10, t0, tr);
            check("filla_one_write", 64'(buf_ev.size()), 64'd1);
            be = buf_ev.pop_front();
            check("filla_addr", 64'(be.addr), 64'(n));
            check("filla_sel", 64'(be.sel), 64'd0);
            check("filla_data", be.data, 64'(n));
        end
        for (int n = 0; n < N; n++) begin
            run_cmd("fillb", OP_FILLB, (n / DIM == n % DIM) ? 64'd1 : 64'd0, 64'(n), 10, t0, tr);
            check("fillb_one_write", 64'(buf_ev.size()), 64'd1);
            be = buf_ev.pop_front();
            check("fillb_addr", 64'(be.addr), 64'(n));
            check("fillb_sel", 64'(be.sel), 64'd1);
        end

        run_cmd("nop", 6'd0, 64'h1234, 64'd0, 10, t0, tr);
        check("nop_no_write", 64'(buf_ev.size()), 64'd0);

        // MULT of A (element n) by the identity: result equals A.
        res_ev.delete();
        run_cmd("mult", OP_MULT, '0, 64'(N), 1100, t0, tr);
        check("mult_latency", 64'(tr - t0), 64'(DIM * DIM * DIM + 2));
        check("mult_write_count", 64'(res_ev.size()), 64'(N));
        for (int n = 0; n < N && res_ev.size() > 0; n++) begin
            re = res_ev.pop_front();
            check("mult_write_time", 64'(int'(re.t) - t0), 64'(11 + 10 * n));
            check("mult_write_addr", 64'(re.addr), 64'(n));
        end

        for (int n = 0; n <= N; n++) begin
            run_cmd("read", OP_READ, '0, 64'(n % N), 10, t0, tr);
        end

        // Refill continues from the current (wrapped) pointer; data matches what is already stored.
        buf_ev.delete();
        run_cmd("refill0", OP_FILLA, 64'd0, STRICT ? ONES : 64'd0, 10, t0, tr);
        run_cmd("refill1", OP_FILLA, 64'd1, STRICT ? ONES : 64'd1, 10, t0, tr);
        check("refill_writes", 64'(buf_ev.size()), STRICT ? 64'd0 : 64'd2);

        // Reset in the middle of a second MULT.
        res_ev.delete();
        cmd_val = 1'b1;
        cmd_opcode = OP_MULT;
        @(negedge clk);
        cmd_val = 1'b0;
        t0 = cyc;
        while (cyc < t0 + 500) @(negedge clk);
        check("mid_mult_mac_en", 64'(mac_en), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_mult_reset_outputs", 64'(any_out()), 64'd0);
        $display("txn reset_mid_mult beat=%0d", cyc - t0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hits = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (resp_val || res_wr_en || mac_en) hits++;
        end
        check("post_reset_quiet", 64'(hits), 64'd0);

        run_cmd("init_after_reset", OP_INIT, '0, 64'd0, 10, t0, tr);
        run_cmd("read_after_init0", OP_READ, '0, STRICT ? ONES : 64'd0, 10, t0, tr);
        run_cmd("read_after_init1", OP_READ, '0, STRICT ? ONES : 64'd1, 10, t0, tr);
        buf_ev.delete();
        run_cmd("filla_after_reset", OP_FILLA, 64'd0, 64'd0, 10, t0, tr);
        check("filla_after_reset_write", 64'(buf_ev.size()), 64'd1);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
